register_file: RTL
==================

# register_file

Parametrised successor to the CPU's general-purpose register bank. It provides two asynchronous read ports and one synchronous write port, with configurable data width and depth. It has a hard-wired zero register (ARM XZR semantics), a sequential clear engine that zeroes every entry after reset or on request, and an optional write-to-read bypass. It sits between decode (read addresses) and writeback (write port) in the datapath.

## Interface
- DATA_WIDTH, 64, width of each register and of all data ports
- ADDR_WIDTH, 5, address width; depth DEPTH = 2**ADDR_WIDTH
- ZERO_REG, 31, index that always reads 0 and ignores writes; must be < DEPTH

- clock  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- clear  input  1  request a full zeroing sweep (sampled in IDLE only)
- write  input  1  write enable
- write_address  input  ADDR_WIDTH  write target index
- write_data  input  DATA_WIDTH  write value
- read_address_1  input  ADDR_WIDTH  read port 1 index
- read_address_2  input  ADDR_WIDTH  read port 2 index
- read_data_1  output  DATA_WIDTH  read port 1 data (combinational)
- read_data_2  output  DATA_WIDTH  read port 2 data (combinational)
- ready  output  1  high when the block is IDLE; writes are accepted only when ready=1

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset directly, so it infers RAM. Contents are defined only via clear sweep or writes.
- FSM states: CLEAR, IDLE. Clear counter clear_index is ADDR_WIDTH bits.
- Reset (reset_n=0): state=CLEAR, clear_index=0, ready=0 immediately, asynchronously.
- CLEAR: each cycle, array[clear_index] <= 0 and clear_index increments.
  - When clear_index == DEPTH-1, go to IDLE next edge; clear_index wraps to 0.
  - The write port is ignored.
  - clear is ignored; the sweep never restarts.
- IDLE: ready=1.
  - A write is accepted when write=1 and write_address != ZERO_REG: array[write_address] <= write_data on the edge.
  - Writes to ZERO_REG are dropped silently.
  - clear=1 moves the FSM to CLEAR on the next edge with clear_index=0.
  - If write and clear are asserted in the same IDLE cycle, the write is performed, then the sweep overwrites it.
- Reads:
  - read_data_n = 0 if ready=0 or read_address_n == ZERO_REG; otherwise array[read_address_n].
  - Both ports are independent; identical addresses are legal.
- Reset mid-sweep or mid-write: the FSM returns to CLEAR with clear_index=0. A write on an edge coincident with reset assertion is not guaranteed.

## Timing
- Read latency: 0 cycles (combinational from address).
- Write latency: data is visible on the read port the cycle after the accepting edge. With bypass it is visible in the same cycle (see Configuration).
- Clear duration: exactly DEPTH cycles.
  - ready rises after the DEPTH-th rising edge following reset_n deassertion, or following the edge that sampled clear.
  - Default configuration: 32 cycles.
- ready is a registered state decode with no combinational path from inputs.
- Reset values: ready=0, read_data_1=0, read_data_2=0, clear_index=0, state=CLEAR.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When ready=1, write=1, write_address == read_address_n and write_address != ZERO_REG, read_data_n = write_data combinationally in the same cycle.
  - This applies to each port independently.
- REGFILE_BYPASS_EN undefined:
  - No forwarding. read_data_n shows the pre-write array value until the edge after the write.
  - No combinational path from write_* to read_data_*.

## Test plan
- Reset release -> ready=0 and both reads=0 for 32 cycles; ready=1 on cycle 32; every address reads 0x0.
- IDLE: write 0xDEADBEEF_CAFEF00D to addr 5, then read addr 5 on both ports -> both show 0xDEADBEEF_CAFEF00D from the next cycle. With REGFILE_BYPASS_EN, it also shows in the write cycle.
- Write 0x1234 to addr 31 (ZERO_REG), then read 31 -> 0x0; other entries are unchanged.
- Fill addr 0..30 with value=index, pulse clear -> ready drops next cycle for 32 cycles; afterwards all reads are 0. Writes issued during the sweep (addr 3, 0xFF) have no effect.
- Assert reset_n=0 at sweep cycle 10 of a clear, release after 2 cycles -> the sweep restarts at index 0, and ready=1 exactly 32 cycles after release.
- Same-cycle write addr 7 = 0xAA plus clear in IDLE -> after the sweep, addr 7 reads 0x0.

Source files
------------

// File: rtl/register_file.sv
// register_file: 2R/1W register bank with a hard-wired zero register,
// a sequential clear sweep, and an optional write-to-read bypass.
//
// Ports: clock, reset_n (async, active-low); clear starts a sweep
//   (sampled only when idle); write/write_address/write_data form the
//   write port; read_address_n/read_data_n are combinational reads;
//   ready is high only when idle.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the reads.
module register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] read_address_1,
  input  logic [ADDR_WIDTH-1:0] read_address_2,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZR =
    ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] clear_index_q;
  logic [ADDR_WIDTH-1:0] clear_index_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;

  // The sweep and the write port share the single RAM write port.
  always_comb begin
    state_d       = state_q;
    clear_index_d = clear_index_q;
    mem_we        = 1'b0;
    mem_wa        = write_address;
    mem_wd        = write_data;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we        = 1'b1;
        mem_wa        = clear_index_q;
        mem_wd        = '0;
        clear_index_d = clear_index_q + 1'b1;
        if (clear_index_q == LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (write && (write_address != ZR)) begin
          mem_we = 1'b1;
        end
        if (clear) begin
          state_d       = ST_CLEAR;
          clear_index_d = '0;
        end
      end
      default: begin
        state_d       = ST_CLEAR;
        clear_index_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_CLEAR;
      clear_index_q <= '0;
    end else begin
      state_q       <= state_d;
      clear_index_q <= clear_index_d;
    end
  end

  // Storage is left unreset so it maps onto RAM.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign ready = (state_q == ST_IDLE);

`ifdef REGFILE_BYPASS_EN
  logic wr_live;
  assign wr_live = ready && write && (write_address != ZR);
`endif

  always_comb begin
    read_data_1 = '0;
    if (ready && (read_address_1 != ZR)) begin
      read_data_1 = mem_q[read_address_1];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_live && (write_address == read_address_1)) begin
      read_data_1 = write_data;
    end
`endif
  end

  always_comb begin
    read_data_2 = '0;
    if (ready && (read_address_2 != ZR)) begin
      read_data_2 = mem_q[read_address_2];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_live && (write_address == read_address_2)) begin
      read_data_2 = write_data;
    end
`endif
  end

endmodule
